// File: rtl/icache_direct_pkg.sv
// icache_direct_pkg: state encoding, default cache geometry and the
// little-endian byte-to-word assembly shared by the instruction cache.
package icache_direct_pkg;
  localparam int DEF_INDEX_BITS  = 4;
  localparam int DEF_OFFSET_BITS = 4;
  localparam int DEF_RESP_GAP    = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    FILL_WAIT = 3'd2,
    FILL      = 3'd3,
    RESP      = 3'd4,
    GAP       = 3'd5
  } state_t;

  function automatic logic [31:0] le_word(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: tag/valid/data array, one combinational read port and
// one full-line write port; only the valid bits are reset.
module icache_line_store #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 24,
  parameter int LINE_BITS  = 128
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [LINE_BITS-1:0]  o_rd_line,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [LINE_BITS-1:0]  i_wr_line
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     r_valid;
  logic [TAG_BITS-1:0]  r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];

  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) r_valid <= '0;
    else if (i_we) r_valid[i_wr_idx] <= 1'b1;

  always_ff @(posedge clk_in)
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_line;
    end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache, byte-wide line fill on miss.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int RESP_GAP    = DEF_RESP_GAP
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        to_icache,
  input  logic [31:0] pc_to_icache,
  output logic        have_result,
  output logic [31:0] inst_from_icache,
  input  logic        clear_in,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int LINE_BYTES = 1 << OFFSET_BITS;
  localparam int LINE_BITS  = 8 * LINE_BYTES;
  localparam int K_W        = OFFSET_BITS + 1;
  localparam logic [K_W-1:0]         K_ONE   = 1;
  localparam logic [OFFSET_BITS-1:0] OFF_ONE = 1;

  state_t                 r_state, w_next;
  logic [31:2]            r_pc;
  logic [K_W-1:0]         r_k;
  logic [7:0]             r_gap;
  logic                   r_supp;
  logic [LINE_BITS-1:0]   r_buf, w_fill_line, w_rd_line;
  logic                   w_rd_valid, w_hit, w_fill_done, w_lookup_hit, w_lookup_miss;
  logic [TAG_BITS-1:0]    w_rd_tag, w_tag;
  logic [INDEX_BITS-1:0]  w_idx;
  logic [OFFSET_BITS-3:0] w_word;
  logic                   w_have_d, w_req_d;
  logic [31:0]            w_inst_d, w_mem_a_d;
  logic                   w_unused;

  function automatic logic [31:0] pick(input logic [LINE_BITS-1:0] line, input logic [OFFSET_BITS-3:0] w);
    logic [31:0] raw;
    raw = line[{w, 5'd0} +: 32];
    return le_word(raw[7:0], raw[15:8], raw[23:16], raw[31:24]);
  endfunction

  assign w_unused      = ^pc_to_icache[1:0];
  assign w_tag         = r_pc[31:OFFSET_BITS+INDEX_BITS];
  assign w_idx         = r_pc[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_word        = r_pc[OFFSET_BITS-1:2];
  assign w_hit         = w_rd_valid && w_rd_tag == w_tag;
  assign w_fill_done   = r_state == FILL && r_k == K_W'(LINE_BYTES);
  assign w_lookup_hit  = r_state == LOOKUP && !clear_in && w_hit;
  assign w_lookup_miss = r_state == LOOKUP && !clear_in && !w_hit;

  icache_line_store #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS), .LINE_BITS(LINE_BITS)) u_store (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_rd_idx  (w_idx),
    .o_rd_valid(w_rd_valid),
    .o_rd_tag  (w_rd_tag),
    .o_rd_line (w_rd_line),
    .i_we      (w_fill_done && rdy_in),
    .i_wr_idx  (w_idx),
    .i_wr_tag  (w_tag),
    .i_wr_line (w_fill_line)
  );

  // The last byte is still on mem_din when the line is committed.
  always_comb begin
    w_fill_line = r_buf;
    w_fill_line[LINE_BITS-8 +: 8] = mem_din;
  end

  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) r_state <= IDLE;
    else if (rdy_in) r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = (to_icache && r_gap == 8'd0) ? LOOKUP : IDLE;
      LOOKUP:    w_next = (clear_in || w_hit) ? GAP : FILL_WAIT;
      FILL_WAIT: w_next = mem_grant ? FILL : FILL_WAIT;
      FILL:      w_next = w_fill_done ? RESP : FILL;
      RESP:      w_next = GAP;
      GAP:       w_next = (r_gap <= 8'd1) ? IDLE : GAP;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_have_d  = w_lookup_hit || (w_fill_done && !r_supp && !clear_in);
    w_inst_d  = w_lookup_hit ? pick(w_rd_line, w_word) : w_have_d ? pick(w_fill_line, w_word) : inst_from_icache;
    w_req_d   = w_lookup_miss ? 1'b1 : w_fill_done ? 1'b0 : mem_req;
    w_mem_a_d = (r_state == FILL_WAIT && mem_grant) ? {r_pc[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}} :
                (r_state == FILL && r_k < K_W'(LINE_BYTES - 1)) ? {r_pc[31:OFFSET_BITS], r_k[OFFSET_BITS-1:0] + OFF_ONE} :
                mem_a;
  end

  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      have_result      <= 1'b0;
      inst_from_icache <= '0;
      mem_req          <= 1'b0;
      mem_a            <= '0;
    end else if (rdy_in) begin
      have_result      <= w_have_d;
      inst_from_icache <= w_inst_d;
      mem_req          <= w_req_d;
      mem_a            <= w_mem_a_d;
    end

  // r_k counts issued addresses; byte r_k-1 is on mem_din while r_k is nonzero.
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      r_pc   <= '0;
      r_k    <= '0;
      r_gap  <= '0;
      r_supp <= 1'b0;
      r_buf  <= '0;
    end else if (rdy_in) begin
      if (r_state == IDLE && w_next == LOOKUP) r_pc <= pc_to_icache[31:2];
      r_k <= (r_state == FILL && !w_fill_done) ? r_k + K_ONE : '0;
      if (r_state == FILL && r_k != '0) r_buf[{r_k[OFFSET_BITS-1:0] - OFF_ONE, 3'd0} +: 8] <= mem_din;
      r_gap <= (r_state != GAP && w_next == GAP) ? 8'(RESP_GAP) : (r_state == GAP) ? r_gap - 8'd1 : r_gap;
      r_supp <= !w_fill_done && (r_supp || (clear_in && (r_state == FILL_WAIT || r_state == FILL)));
    end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rdy_in) begin
      hit_count  <= hit_count + {31'd0, w_lookup_hit};
      miss_count <= miss_count + {31'd0, w_lookup_miss};
    end
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: randomized fetch traffic against a per-index line model,
// with a byte RAM and a delayed-grant arbiter modelled in the bench.
module tb_icache_direct;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, to_icache, clear_in, mem_grant;
  logic [31:0] pc_to_icache, inst_from_icache, mem_a;
  logic        have_result, mem_req;
  logic [7:0]  mem_din;

  logic [7:0]  ram [65536];
  logic        mv  [16];
  logic [23:0] mt  [16];
  int          grant_dly, req_cyc, n_vec, n_err;
  logic        r_prev_g;

  icache_direct dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .to_icache       (to_icache),
    .pc_to_icache    (pc_to_icache),
    .have_result     (have_result),
    .inst_from_icache(inst_from_icache),
    .clear_in        (clear_in),
    .mem_req         (mem_req),
    .mem_grant       (mem_grant),
    .mem_a           (mem_a),
    .mem_din         (mem_din)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (rdy_in) mem_din <= ram[mem_a[15:0]];

  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) req_cyc <= 0;
    else if (rdy_in) req_cyc <= mem_req ? req_cyc + 1 : 0;

  assign mem_grant = mem_req && req_cyc >= grant_dly;

  always @(posedge clk_in) begin
    if (rst_in && rdy_in && r_prev_g && mem_req) assert (mem_grant) else $error("FAIL grant_drop: grant fell during fill");
    if (rdy_in) r_prev_g <= mem_grant;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // clr_k: -1 none, -2 clear in the lookup cycle, >=0 clear when mem_a shows byte k.
  task automatic do_req(input logic [31:0] pc, input int gdly, input int clr_k_in,
                        input int pz_k_in, input int pz_len, input int rst_k);
    int idx, clr_k, pz_k, t_req, t_grant, t_have, n_have, n_seq, pz_left, quiet;
    logic hit, done, seen, clr_done, pz_done, rst_done;
    logic [31:0] base, exp_w, last_a;
    idx      = int'(pc[7:4]);
    hit      = mv[idx] && mt[idx] == pc[31:8];
    clr_k    = (hit && clr_k_in >= 0) ? -1 : clr_k_in;
    pz_k     = hit ? -1 : pz_k_in;
    base     = {pc[31:4], 4'h0};
    exp_w    = {ram[pc[15:0] + 16'd3], ram[pc[15:0] + 16'd2], ram[pc[15:0] + 16'd1], ram[pc[15:0]]};
    grant_dly = gdly;
    t_req = -1; t_grant = -1; t_have = -1; n_have = 0; n_seq = 0; pz_left = 0; quiet = 0;
    done = 0; seen = 0; clr_done = 0; pz_done = 0; rst_done = 0; last_a = '0;
    @(negedge clk_in);
    to_icache = 1'b1;
    pc_to_icache = pc;
    for (int t = 1; t <= 150 && !done; t++) begin
      @(negedge clk_in);
      clear_in = 1'b0;
      if (pz_left > 0) begin rdy_in = 1'b0; pz_left--; end else rdy_in = 1'b1;
      if (mem_req && t_req < 0) t_req = t;
      if (mem_req && mem_grant && t_grant < 0) t_grant = t;
      if (t_grant >= 0 && t > t_grant && mem_req && (!seen || mem_a != last_a)) begin
        if (mem_a == base + 32'(n_seq)) n_seq++;
        seen = 1; last_a = mem_a;
      end
      quiet = (mem_req || have_result) ? 0 : quiet + 1;
      if (have_result) begin
        n_have++;
        if (t_have < 0) t_have = t;
        chk("inst", inst_from_icache, exp_w);
        to_icache = 1'b0;
      end
      if ((t_have >= 0 && t >= t_have + 3) || quiet >= 8) done = 1;
      if (clr_k == -2 && t == 1) begin clear_in = 1'b1; to_icache = 1'b0; end
      if (t_grant >= 0 && t > t_grant && mem_req) begin
        if (clr_k >= 0 && !clr_done && mem_a == base + 32'(clr_k)) begin
          clear_in = 1'b1; to_icache = 1'b0; clr_done = 1;
        end
        if (pz_k >= 0 && !pz_done && mem_a == base + 32'(pz_k)) begin
          rdy_in = 1'b0; pz_left = pz_len - 1; pz_done = 1;
        end
        if (rst_k >= 0 && !hit && mem_a == base + 32'(rst_k)) begin
          rst_in = 1'b0;
          #1;
          chk("rst_have", {31'd0, have_result}, 32'd0);
          chk("rst_req", {31'd0, mem_req}, 32'd0);
          chk("rst_mem_a", mem_a, 32'd0);
          chk("rst_inst", inst_from_icache, 32'd0);
          @(negedge clk_in);
          rst_in = 1'b1; to_icache = 1'b0; rdy_in = 1'b1;
          for (int i = 0; i < 16; i++) mv[i] = 1'b0;
          done = 1; rst_done = 1;
        end
      end
    end
    to_icache = 1'b0;
    clear_in  = 1'b0;
    rdy_in    = 1'b1;
    if (!done) chk("timeout", 32'd0, 32'd1);
    if (rst_done) return;
    if (hit || clr_k == -2) chk("no_req", t_req, -1);
    else begin
      chk("req_t", t_req, 2);
      chk("grant_t", t_grant, 2 + gdly);
      chk("mem_a_seq", n_seq, 16);
      mv[idx] = 1'b1;
      mt[idx] = pc[31:8];
    end
    chk("have_cnt", n_have, (clr_k == -1) ? 1 : 0);
    if (clr_k == -1 && hit) chk("hit_lat", t_have, 2);
    if (clr_k == -1 && !hit) chk("miss_lat", t_have - t_grant, 18 + (pz_k >= 0 ? pz_len : 0));
  endtask

  initial begin
    logic [31:0] pc;
    int sel;
    n_vec = 0; n_err = 0; grant_dly = 0; r_prev_g = 1'b0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'h00; ram[3] = 8'h00;
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mt[i] = '0; end
    rst_in = 1'b0; rdy_in = 1'b1; to_icache = 1'b0; clear_in = 1'b0; pc_to_icache = '0;
    repeat (3) @(negedge clk_in);
    chk("reset_have", {31'd0, have_result}, 32'd0);
    chk("reset_inst", inst_from_icache, 32'd0);
    chk("reset_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_a", mem_a, 32'd0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    do_req(32'h0000, 0, -1, -1, 0, -1);
    chk("cold_inst", inst_from_icache, 32'h0000_0013);
    do_req(32'h0004, 0, -1, -1, 0, -1);
    do_req(32'h0100, 1, -1, -1, 0, -1);
    do_req(32'h0000, 0, -1, -1, 0, -1);
    do_req(32'h0100, 0, -1, -1, 0, -1);
    do_req(32'h0000, 0, 5, -1, 0, -1);
    do_req(32'h0008, 0, -1, -1, 0, -1);
    do_req(32'h0030, 0, -1, 8, 3, -1);
    do_req(32'h0040, 2, -2, -1, 0, -1);
    do_req(32'h0040, 0, -1, -1, 0, -1);
    do_req(32'h0050, 0, -1, -1, 0, 6);
    do_req(32'h0004, 0, -1, -1, 0, -1);

    for (int i = 0; i < 60; i++) begin
      pc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
      sel = int'($urandom_range(0, 9));
      do_req(pc, int'($urandom_range(0, 3)),
             sel == 0 ? -2 : sel == 1 ? int'($urandom_range(0, 15)) : -1,
             sel == 2 ? int'($urandom_range(0, 15)) : -1,
             int'($urandom_range(1, 4)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
